load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Data-memory access stage directly downstream of the instruction decoder in the single-cycle core.
- Consumes MemReadEn, MemWriteEn and MemoryOperation from the decoder, the ALU result as the address, and rs2 as the store data.
- Drives a req/ack data bus with byte enables, then aligns and extends load data for the register write-back mux (Mem2Reg = 1).
- Holds the core through the Stall output while a bus access is outstanding.

Parameters:
- TIMEOUT_CYCLES, 16: maximum number of ACCESS cycles waiting for BusAck before the unit aborts with a bus error.
- DATA_W, 32: width of the data and address paths.

Ports:
- Clk  in  1  core clock; all state changes on the rising edge.
- Rst  in  1  synchronous, active-high reset.
- MemReadEn  in  1  load request from the decoder.
- MemWriteEn  in  1  store request from the decoder.
- MemoryOperation  in  3  `LB/LH/LW/LBU/LHU/SB/SH/SW_OPERATION codes from Constants.vh.
- Address  in  32  byte address (ALU result).
- StoreData  in  32  rs2 value.
- LoadData  out  32  aligned, extended load result (registered).
- Stall  out  1  freezes PC and register-file write while high.
- Misaligned  out  1  one-cycle pulse on a misaligned access.
- BusError  out  1  one-cycle pulse on a timeout.
- BusReq  out  1  bus request.
- BusWe  out  1  bus write enable.
- BusAddr  out  32  word address: {Address[31:2], 2'b00}.
- BusByteEn  out  4  byte-lane enables.
- BusWData  out  32  write data.
- BusRData  in  32  read data; valid while BusAck is high.
- BusAck  in  1  one-cycle completion strobe.

Behaviour:
- Request condition: req = MemReadEn | MemWriteEn. If both are high, the access is treated as a store.
- Alignment check:
  - H ops are misaligned when Address[0] = 1.
  - W ops are misaligned when Address[1:0] != 0.
  - B ops are never misaligned.
- States: IDLE, ACCESS, DONE. Reset state is IDLE.
- Reset values: LoadData = 0; Stall = 0 (no request present); all pulses = 0; BusReq = 0, BusWe = 0, BusAddr = 0, BusByteEn = 0, BusWData = 0.
- IDLE, req high and aligned:
  - Latch op, BusAddr, BusByteEn, BusWData and BusWe.
  - Go to ACCESS.
  - Stall = 1 combinationally in this same cycle.
- IDLE, req high and misaligned:
  - No bus activity.
  - Misaligned = 1 for this cycle, Stall = 0.
  - LoadData <= 0; stay in IDLE.
- ACCESS:
  - BusReq = 1 and Stall = 1; the latched bus outputs are held stable.
  - Timeout counter increments every ACCESS cycle.
  - On BusAck: capture and format BusRData into LoadData (loads only), go to DONE.
  - On timeout (counter reaches TIMEOUT_CYCLES - 1 with no ack): LoadData <= 0, BusError = 1 for one cycle (registered, asserted in DONE), go to DONE.
- DONE:
  - Stall = 0 and BusReq = 0 for exactly one cycle; the core commits at this edge.
  - Next state is unconditionally IDLE. The new instruction is evaluated there, so back-to-back accesses cost 3 cycles minimum.
- Store byte enables, where a = Address[1:0]:
  - SB: BusByteEn = 4'b0001 << a; BusWData = byte replicated x4.
  - SH: 4'b0011 << a; BusWData = halfword replicated x2.
  - SW: 4'b1111; BusWData = StoreData.
  - BusByteEn = 4'b1111 for loads.
- Load formatting:
  - B ops select byte a; H ops select halfword a[1].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- LoadData holds its value until the next completed load, misaligned load or timeout.
- The counter resets on every entry to ACCESS.
- BusAck outside ACCESS is ignored.
- BusAck in the timeout cycle wins: data is captured and no error is raised.
- Rst mid-ACCESS: next edge goes to IDLE, BusReq = 0, counter cleared, LoadData = 0. No pulse is generated.
- An unknown MemoryOperation with req high is treated as LW/SW.

Test Plan:
- LW at Address 0x100, BusAck returned after 2 cycles with BusRData 0xDEADBEEF:
  - Stall is high 3 cycles (IDLE, ACCESS x2); DONE follows.
  - LoadData = 0xDEADBEEF; BusAddr = 0x100; BusByteEn = 4'b1111.
- LB at 0x103, BusRData 0x80FF_FF7F → LoadData = 0xFFFFFF80.
- LBU at the same address and data → LoadData = 0x00000080.
- LH at 0x102, BusRData 0x8001_0000 → LoadData = 0xFFFF8001.
- SB at 0x201 with StoreData 0x123456AB:
  - BusWe = 1, BusByteEn = 4'b0010, BusWData = 0xABABABAB, BusAddr = 0x200.
- SH at 0x202 with StoreData 0x0000BEEF:
  - BusByteEn = 4'b1100, BusWData = 0xBEEFBEEF.
- LW at 0x102 → Misaligned pulses for 1 cycle, Stall = 0, BusReq never high, LoadData = 0.
- Ack never returned with TIMEOUT_CYCLES = 16:
  - BusReq is high for exactly 16 cycles, then BusError pulses once in DONE, LoadData = 0, then IDLE.
- Rst asserted in the 2nd ACCESS cycle:
  - After the edge: BusReq = 0, Stall = 0 (no request present), state IDLE.
  - A later BusAck has no effect.

Source files
------------

// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
// Data-memory access stage of the single-cycle core. It takes the decoder's
// load/store request, drives a req/ack data bus with byte enables, and returns
// an aligned, sign- or zero-extended load result to the write-back mux. The
// core is frozen through Stall while a bus access is outstanding.
//
// Ports
//   Clk, Rst          core clock, synchronous active-high reset
//   MemReadEn         load request
//   MemWriteEn        store request (wins when both requests are high)
//   MemoryOperation   funct3-style op code (LB/LH/LW/LBU/LHU, SB/SH/SW)
//   Address           byte address from the ALU
//   StoreData         rs2 value
//   LoadData          registered, formatted load result
//   Stall             holds PC and register-file write while high
//   Misaligned        one-cycle pulse on a misaligned request
//   BusError          one-cycle pulse after a bus timeout
//   BusReq/BusWe/BusAddr/BusByteEn/BusWData   bus request side
//   BusRData/BusAck   bus response side
// -----------------------------------------------------------------------------
module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int DATA_W         = 32
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              MemReadEn,
  input  logic              MemWriteEn,
  input  logic [2:0]        MemoryOperation,
  input  logic [DATA_W-1:0] Address,
  input  logic [DATA_W-1:0] StoreData,
  output logic [DATA_W-1:0] LoadData,
  output logic              Stall,
  output logic              Misaligned,
  output logic              BusError,
  output logic              BusReq,
  output logic              BusWe,
  output logic [DATA_W-1:0] BusAddr,
  output logic [3:0]        BusByteEn,
  output logic [DATA_W-1:0] BusWData,
  input  logic [DATA_W-1:0] BusRData,
  input  logic              BusAck
);

  // Operation codes (funct3 encoding shared with the decoder).
  localparam logic [2:0] OP_B  = 3'b000;
  localparam logic [2:0] OP_H  = 3'b001;
  localparam logic [2:0] OP_W  = 3'b010;
  localparam logic [2:0] OP_BU = 3'b100;
  localparam logic [2:0] OP_HU = 3'b101;

  // Access sizes.
  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  // FSM states.
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  // Byte-lane enables for a store of the given size at byte offset a.
  function automatic logic [3:0] byte_en_f(input logic [1:0] size, input logic [1:0] a);
    case (size)
      SZ_B:    byte_en_f = 4'b0001 << a;
      SZ_H:    byte_en_f = 4'b0011 << a;
      default: byte_en_f = 4'b1111;
    endcase
  endfunction

  // Store data replicated across all lanes so the byte enables pick the lane.
  function automatic logic [DATA_W-1:0] wdata_f(input logic [1:0] size, input logic [DATA_W-1:0] sd);
    case (size)
      SZ_B:    wdata_f = {4{sd[7:0]}};
      SZ_H:    wdata_f = {2{sd[15:0]}};
      default: wdata_f = sd;
    endcase
  endfunction

  // Select the addressed byte/halfword of the bus word and extend it.
  function automatic logic [DATA_W-1:0] load_fmt_f(input logic [1:0] size, input logic sext,
                                                   input logic [1:0] a, input logic [DATA_W-1:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{a, 3'b000} +: 8];
    h = a[1] ? w[31:16] : w[15:0];
    case (size)
      SZ_B:    load_fmt_f = sext ? {{(DATA_W-8){b[7]}}, b}  : {{(DATA_W-8){1'b0}}, b};
      SZ_H:    load_fmt_f = sext ? {{(DATA_W-16){h[15]}}, h} : {{(DATA_W-16){1'b0}}, h};
      default: load_fmt_f = w;
    endcase
  endfunction

  logic [1:0]        state_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [1:0]        size_r;
  logic              sext_r;
  logic [1:0]        addr_lo_r;
  logic              bus_we_r;
  logic [DATA_W-1:0] bus_addr_r;
  logic [3:0]        bus_byte_en_r;
  logic [DATA_W-1:0] bus_wdata_r;
  logic [DATA_W-1:0] load_data_r;
  logic              bus_error_r;

  logic              req_s;
  logic [1:0]        size_s;
  logic              sext_s;
  logic              misaligned_s;

  // Decode the request: size, extension and alignment of the current op.
  // Codes outside the defined set (including U variants on stores) act as word.
  always_comb begin
    req_s  = MemReadEn | MemWriteEn;
    size_s = SZ_W;
    sext_s = 1'b0;
    case (MemoryOperation)
      OP_B:    begin size_s = SZ_B; sext_s = 1'b1; end
      OP_H:    begin size_s = SZ_H; sext_s = 1'b1; end
      OP_W:    begin size_s = SZ_W; sext_s = 1'b0; end
      OP_BU:   begin size_s = MemWriteEn ? SZ_W : SZ_B; sext_s = 1'b0; end
      OP_HU:   begin size_s = MemWriteEn ? SZ_W : SZ_H; sext_s = 1'b0; end
      default: begin size_s = SZ_W; sext_s = 1'b0; end
    endcase
    if (size_s == SZ_H) begin
      misaligned_s = Address[0];
    end else if (size_s == SZ_W) begin
      misaligned_s = (Address[1:0] != 2'b00);
    end else begin
      misaligned_s = 1'b0;
    end
  end

  // Stall is raised in the accepting IDLE cycle so the core freezes at once.
  always_comb begin
    Stall      = 1'b0;
    Misaligned = 1'b0;
    if (state_r == ST_IDLE) begin
      Stall      = req_s & ~misaligned_s;
      Misaligned = req_s & misaligned_s;
    end else if (state_r == ST_ACCESS) begin
      Stall = 1'b1;
    end else begin
      Stall = 1'b0;
    end
  end

  assign BusReq    = (state_r == ST_ACCESS);
  assign BusWe     = bus_we_r;
  assign BusAddr   = bus_addr_r;
  assign BusByteEn = bus_byte_en_r;
  assign BusWData  = bus_wdata_r;
  assign LoadData  = load_data_r;
  assign BusError  = bus_error_r;

  // Access FSM: latch request, wait for ack or timeout, one DONE commit cycle.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_r       <= ST_IDLE;
      cnt_r         <= '0;
      size_r        <= SZ_W;
      sext_r        <= 1'b0;
      addr_lo_r     <= 2'b00;
      bus_we_r      <= 1'b0;
      bus_addr_r    <= '0;
      bus_byte_en_r <= 4'b0000;
      bus_wdata_r   <= '0;
      load_data_r   <= '0;
      bus_error_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          bus_error_r <= 1'b0;
          if (req_s && misaligned_s) begin
            // Misaligned loads return zero; a misaligned store leaves it alone.
            if (!MemWriteEn) begin
              load_data_r <= '0;
            end
          end else if (req_s) begin
            size_r        <= size_s;
            sext_r        <= sext_s;
            addr_lo_r     <= Address[1:0];
            bus_we_r      <= MemWriteEn;
            bus_addr_r    <= {Address[DATA_W-1:2], 2'b00};
            bus_byte_en_r <= MemWriteEn ? byte_en_f(size_s, Address[1:0]) : 4'b1111;
            bus_wdata_r   <= wdata_f(size_s, StoreData);
            cnt_r         <= '0;
            state_r       <= ST_ACCESS;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_ACCESS: begin
          // Ack is checked first so an ack in the final cycle still completes.
          if (BusAck) begin
            if (!bus_we_r) begin
              load_data_r <= load_fmt_f(size_r, sext_r, addr_lo_r, BusRData);
            end
            state_r <= ST_DONE;
          end else if (cnt_r == CNT_LAST) begin
            load_data_r <= '0;
            bus_error_r <= 1'b1;
            state_r     <= ST_DONE;
          end else begin
            cnt_r <= cnt_r + 1'b1;
          end
        end
        ST_DONE: begin
          bus_error_r <= 1'b0;
          state_r     <= ST_IDLE;
        end
        default: begin
          bus_error_r <= 1'b0;
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// -----------------------------------------------------------------------------
// tb_load_store_unit
// Directed scenarios followed by randomized loads/stores, each checked against
// a transaction-level reference model (byte arithmetic on the bus word).
// -----------------------------------------------------------------------------
module tb_load_store_unit;

  localparam int TMO = 16;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        MemReadEn, MemWriteEn;
  logic [2:0]  MemoryOperation;
  logic [31:0] Address, StoreData;
  logic [31:0] LoadData;
  logic        Stall, Misaligned, BusError, BusReq, BusWe;
  logic [31:0] BusAddr, BusWData, BusRData;
  logic [3:0]  BusByteEn;
  logic        BusAck;

  int checks = 0;
  int errors = 0;
  logic [31:0] ld_model = 32'h0;

  load_store_unit #(.TIMEOUT_CYCLES(TMO), .DATA_W(32)) dut (
    .Clk(Clk), .Rst(Rst), .MemReadEn(MemReadEn), .MemWriteEn(MemWriteEn),
    .MemoryOperation(MemoryOperation), .Address(Address), .StoreData(StoreData),
    .LoadData(LoadData), .Stall(Stall), .Misaligned(Misaligned), .BusError(BusError),
    .BusReq(BusReq), .BusWe(BusWe), .BusAddr(BusAddr), .BusByteEn(BusByteEn),
    .BusWData(BusWData), .BusRData(BusRData), .BusAck(BusAck)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Access size in bytes as the decoder's op code defines it.
  function automatic int op_bytes(input logic is_store, input logic [2:0] op);
    if (op == 3'd0) return 1;
    if (op == 3'd1) return 2;
    if (!is_store && op == 3'd4) return 1;
    if (!is_store && op == 3'd5) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] exp_load(input logic [2:0] op, input logic [31:0] addr,
                                           input logic [31:0] w);
    int n; int sh; logic [31:0] v;
    n  = op_bytes(1'b0, op);
    if (n == 4) return w;
    sh = (n == 1) ? 8 * int'(addr % 4) : 16 * int'((addr % 4) / 2);
    v  = (w >> sh) & ((n == 1) ? 32'hFF : 32'hFFFF);
    if (op < 3'd4) begin
      if (n == 1 && v >= 32'h80)   v = v + 32'hFFFF_FF00;
      if (n == 2 && v >= 32'h8000) v = v + 32'hFFFF_0000;
    end
    return v;
  endfunction

  function automatic logic [3:0] exp_be(input logic [2:0] op, input logic [31:0] addr);
    int n; int a; logic [3:0] m;
    n = op_bytes(1'b1, op);
    a = int'(addr % 4);
    m = 4'b0000;
    for (int i = 0; i < n; i++) m[a + i] = 1'b1;
    return m;
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [2:0] op, input logic [31:0] sd);
    int n;
    n = op_bytes(1'b1, op);
    if (n == 1) return (sd % 256) * 32'h0101_0101;
    if (n == 2) return (sd % 65536) * 32'h0001_0001;
    return sd;
  endfunction

  // One complete transaction; ack_at = ACCESS cycle carrying BusAck (0 = never).
  task automatic run_access(input logic rd, input logic wr, input logic [2:0] op,
                            input logic [31:0] addr, input logic [31:0] sd,
                            input logic [31:0] rdata, input int ack_at);
    logic is_store; int n; logic mis; logic tmo; bit done;
    is_store = wr;
    n   = op_bytes(is_store, op);
    mis = (addr % n) != 0;
    @(negedge Clk);
    MemReadEn = rd; MemWriteEn = wr; MemoryOperation = op;
    Address = addr; StoreData = sd; BusAck = 1'b0;
    #1;
    check("idle_buserror", BusError, 1'b0);
    check("idle_busreq", BusReq, 1'b0);
    check("idle_misaligned", Misaligned, mis);
    check("idle_stall", Stall, !mis);
    if (mis) begin
      if (!is_store) ld_model = 32'h0;
      @(negedge Clk);
      MemReadEn = 1'b0; MemWriteEn = 1'b0;
      #1;
      check("mis_after_pulse", Misaligned, 1'b0);
      check("mis_after_busreq", BusReq, 1'b0);
      check("mis_loaddata", LoadData, ld_model);
      return;
    end
    done = 0;
    for (int c = 1; c <= TMO && !done; c++) begin
      @(negedge Clk);
      BusAck   = (c == ack_at);
      BusRData = (c == ack_at) ? rdata : $urandom;
      #1;
      check("acc_busreq", BusReq, 1'b1);
      check("acc_stall", Stall, 1'b1);
      check("acc_busaddr", BusAddr, {addr[31:2], 2'b00});
      check("acc_buswe", BusWe, is_store);
      check("acc_byteen", BusByteEn, is_store ? exp_be(op, addr) : 4'b1111);
      if (is_store) check("acc_wdata", BusWData, exp_wdata(op, sd));
      if (c == ack_at) done = 1;
    end
    tmo = (ack_at < 1 || ack_at > TMO);
    if (tmo) ld_model = 32'h0;
    else if (!is_store) ld_model = exp_load(op, addr, rdata);
    @(negedge Clk);
    // Ack outside ACCESS must be ignored.
    BusAck = $urandom_range(0, 1);
    MemReadEn = 1'b0; MemWriteEn = 1'b0;
    #1;
    check("done_busreq", BusReq, 1'b0);
    check("done_stall", Stall, 1'b0);
    check("done_buserror", BusError, tmo);
    check("done_loaddata", LoadData, ld_model);
  endtask

  initial begin
    Rst = 1'b1; MemReadEn = 1'b0; MemWriteEn = 1'b0; MemoryOperation = 3'd0;
    Address = 32'h0; StoreData = 32'h0; BusRData = 32'h0; BusAck = 1'b0;
    repeat (2) @(negedge Clk);
    #1;
    check("rst_loaddata", LoadData, 32'h0);
    check("rst_stall", Stall, 1'b0);
    check("rst_misaligned", Misaligned, 1'b0);
    check("rst_buserror", BusError, 1'b0);
    check("rst_busreq", BusReq, 1'b0);
    check("rst_buswe", BusWe, 1'b0);
    check("rst_busaddr", BusAddr, 32'h0);
    check("rst_byteen", BusByteEn, 4'h0);
    check("rst_wdata", BusWData, 32'h0);
    @(negedge Clk);
    Rst = 1'b0;

    // Directed scenarios.
    run_access(1'b1, 1'b0, 3'd2, 32'h100, 32'h0, 32'hDEADBEEF, 2);   // LW
    run_access(1'b1, 1'b0, 3'd0, 32'h103, 32'h0, 32'h80FFFF7F, 1);   // LB
    run_access(1'b1, 1'b0, 3'd4, 32'h103, 32'h0, 32'h80FFFF7F, 3);   // LBU
    run_access(1'b1, 1'b0, 3'd1, 32'h102, 32'h0, 32'h80010000, 1);   // LH
    run_access(1'b0, 1'b1, 3'd0, 32'h201, 32'h123456AB, 32'h0, 2);   // SB
    run_access(1'b0, 1'b1, 3'd1, 32'h202, 32'h0000BEEF, 32'h0, 1);   // SH
    run_access(1'b1, 1'b0, 3'd2, 32'h102, 32'h0, 32'h0, 1);          // misaligned LW
    run_access(1'b1, 1'b0, 3'd2, 32'h104, 32'h0, 32'h11223344, 1);
    run_access(1'b1, 1'b0, 3'd2, 32'h108, 32'h0, 32'h0, 0);          // timeout
    run_access(1'b1, 1'b0, 3'd5, 32'h10A, 32'h0, 32'hCAFE1234, TMO); // ack in last cycle
    run_access(1'b1, 1'b1, 3'd2, 32'h300, 32'hA5A5_5A5A, 32'h0, 1);  // both high = store

    // Reset in the second ACCESS cycle.
    @(negedge Clk);
    MemReadEn = 1'b1; MemoryOperation = 3'd2; Address = 32'h400;
    @(negedge Clk);
    @(negedge Clk);
    Rst = 1'b1;
    @(negedge Clk);
    Rst = 1'b0; MemReadEn = 1'b0;
    ld_model = 32'h0;
    #1;
    check("midrst_busreq", BusReq, 1'b0);
    check("midrst_stall", Stall, 1'b0);
    check("midrst_loaddata", LoadData, ld_model);
    @(negedge Clk);
    BusAck = 1'b1; BusRData = 32'hFFFF_FFFF;
    @(negedge Clk);
    BusAck = 1'b0;
    #1;
    check("lateack_busreq", BusReq, 1'b0);
    check("lateack_stall", Stall, 1'b0);
    check("lateack_loaddata", LoadData, ld_model);

    // Randomized transactions.
    for (int t = 0; t < 60; t++) begin
      int kind; logic [2:0] op; logic [31:0] addr; int ack;
      kind = $urandom_range(0, 9);
      op   = 3'($urandom_range(0, 7));
      addr = $urandom;
      ack  = ($urandom_range(0, 11) == 0) ? 0 : $urandom_range(1, 4);
      if (kind < 4) begin
        addr = addr - (addr % op_bytes(1'b0, op));
        run_access(1'b1, 1'b0, op, addr, $urandom, $urandom, ack);
      end else if (kind < 8) begin
        addr = addr - (addr % op_bytes(1'b1, op));
        run_access(1'b0, 1'b1, op, addr, $urandom, $urandom, ack);
      end else if (kind == 8) begin
        op   = 3'd2;
        addr = addr - (addr % 4) + 32'($urandom_range(1, 3));
        run_access(1'b1, 1'b0, op, addr, $urandom, $urandom, ack);
      end else begin
        op   = 3'd1;
        addr = addr | 32'h1;
        run_access(1'b1, 1'b0, op, addr, $urandom, $urandom, ack);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
